alu_exec_unit: RTL and testbench
================================

Name: alu_exec_unit

Overview:
- Parametrised RV32I/RV32M execute unit: ALU control decode, base ALU, and an iterative multiply/divide sequencer in one block.
- Decodes the 2-bit main-decoder alu_op together with funct3/funct7 and produces the result over a valid/ready handshake.
- Base ops complete in 1 cycle; M-extension ops take XLEN+1 cycles.
- Sits between the register-read stage and writeback; stalls the issue side via in_ready.

Parameters:
- XLEN, 32, datapath width in bits (power of 2, >=8)
- ENABLE_M, 1, 1 = decode M-extension ops; 0 = funct7_0 ignored and all ops treated as base

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset, synchronous, active-low
- in_valid  input  1  operation presented
- in_ready  output  1  unit can accept; high only in IDLE
- alu_op  input  2  00 add (ld/st addr), 01 sub (branch compare), 10 R-type, 11 I-type
- funct3  input  3  instr[14:12]
- funct7_5  input  1  instr[30]
- funct7_0  input  1  instr[25], M-extension select (used only when alu_op=10)
- src_a  input  XLEN  operand A
- src_b  input  XLEN  operand B / immediate
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- result  output  XLEN  operation result
- zero  output  1  result == 0, registered with result

Behaviour:
- Reset (rst_n=0 at a rising edge): state=IDLE; out_valid=0; result=0; zero=0; iteration counter=0. in_ready=1 from the first cycle after reset. Reset mid-operation aborts it; no result is produced.
- Handshake:
  - Accept on an edge with in_valid & in_ready. Operands and decoded op are captured at that edge.
  - out_valid holds until an edge with out_ready=1, then the block returns to IDLE.
  - No overlap: in_ready=0 from acceptance until the cycle after output handshake.
  - result and zero are stable while out_valid=1 and out_ready=0.
- Decode:
  - alu_op=00: ADD. alu_op=01: SUB.
  - alu_op=10, funct7_0=0 (or ENABLE_M=0), by funct3:
    - 000: ADD, or SUB if funct7_5
    - 001: SLL
    - 010: SLT
    - 011: SLTU
    - 100: XOR
    - 101: SRL, or SRA if funct7_5
    - 110: OR
    - 111: AND
  - alu_op=11: same table, except funct3=000 is always ADD (funct7_5 ignored); funct7_5 is honoured only for funct3=101.
  - alu_op=10, funct7_0=1, ENABLE_M=1: funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- FSM: IDLE -> EXEC (base op) or ITER (M op) -> DONE -> IDLE.
  - EXEC lasts 0 extra cycles: result registered at the acceptance edge, so out_valid=1 the cycle after acceptance (latency 1).
  - ITER: operand magnitudes formed at acceptance. Shift-add multiply or restoring divide runs 1 bit per cycle for XLEN cycles; the counter counts 0..XLEN-1.
  - Sign fix-up and result selection occur on the final ITER edge, so out_valid rises XLEN+1 cycles after acceptance.
- Arithmetic rules:
  - All add/sub wrap modulo 2^XLEN.
  - Shift amount = src_b[log2(XLEN)-1:0]. SRA replicates src_a[XLEN-1].
  - SLT/SLTU return 0 or 1, zero-extended.
  - MUL returns the low XLEN bits of the product. MULH, MULHSU and MULHU return the high XLEN bits of the 2*XLEN product, with signed x signed, signed x unsigned and unsigned x unsigned operands respectively.
- Divide boundaries:
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = src_a.
  - Signed overflow (src_a = -2^(XLEN-1), src_b = -1): DIV = src_a; REM = 0.
  - Both cases still take the full XLEN+1 cycles.
- Other:
  - zero is computed from the final result for every op.
  - in_valid while busy is ignored; the source must hold it.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=0, result=0, in_ready=1 after release; no op accepted during reset.
- Base decode, XLEN=32: alu_op=10, funct3=000, funct7_5=1, a=5, b=7 -> result 0xFFFFFFFE, zero=0. alu_op=11, same fields -> 12. alu_op=10, funct3=101, funct7_5=1, a=0x80000000, b=4 -> 0xF8000000. Each with out_valid exactly 1 cycle after acceptance.
- Branch/zero: alu_op=01, a=b=0x1234 -> result 0, zero=1. Then hold out_ready=0 for 3 cycles -> result and out_valid stable, in_ready=0 throughout.
- Multiply:
  - MULH a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000000.
  - MULHU same operands -> 0xFFFFFFFE.
  - MUL a=0x00010000, b=0x00010000 -> 0.
  - out_valid asserts at cycle 33 after acceptance.
- Divide edges: DIV 7/0 -> 0xFFFFFFFF. REMU 7/0 -> 7. DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM of the same operands -> 0. DIV -7/2 -> 0xFFFFFFFD. REM -7/2 -> 0xFFFFFFFF.
- Abort and parameter: rst_n=0 at cycle 10 of a DIVU -> no out_valid, IDLE next cycle. ENABLE_M=0 with funct7_0=1, funct3=000 -> plain ADD in 1 cycle. XLEN=16 DIVU 0xFFFF/3 -> 0x5555 with latency 17.

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   RV32I/RV32M execute unit: ALU control decode, single-cycle base ALU and
//   an iterative shift-add multiplier / restoring divider. The unit holds one
//   operation at a time; issue is stalled through in_ready while it is busy.
//
// Ports
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   issue handshake (in_ready high only when idle)
//   alu_op              00 add, 01 sub, 10 R-type, 11 I-type
//   funct3, funct7_5    instr[14:12], instr[30]
//   funct7_0            instr[25], M-extension select for R-type
//   src_a, src_b        operands (src_b may carry the immediate)
//   out_valid/out_ready result handshake
//   result, zero        registered result and result==0 flag
module alu_exec_unit #(
  parameter int unsigned XLEN     = 32,
  parameter bit          ENABLE_M = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  localparam int unsigned CW = $clog2(XLEN);

  // Base ops have a zero-length execute phase: their result is registered at
  // the acceptance edge, so they go straight from IDLE to DONE.
  typedef enum logic [1:0] {S_IDLE, S_ITER, S_DONE} state_e;

  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR,
    OP_AND, OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM,
    OP_REMU
  } op_e;

  state_e          state_q, state_d;
  op_e             op_q, op_d, dec_op;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d, bmag_q, bmag_d;
  logic            neg_q, neg_d, dz_q, dz_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            zero_q, zero_d;

  // ---------------- decode ----------------
  logic is_m;
  assign is_m = ENABLE_M && (alu_op == 2'b10) && funct7_0;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    dec_op = OP_ADD;
    if (alu_op == 2'b01) begin
      dec_op = OP_SUB;
    end else if (alu_op[1]) begin
      if (is_m) begin
        case (funct3)
          3'b000:  dec_op = OP_MUL;
          3'b001:  dec_op = OP_MULH;
          3'b010:  dec_op = OP_MULHSU;
          3'b011:  dec_op = OP_MULHU;
          3'b100:  dec_op = OP_DIV;
          3'b101:  dec_op = OP_DIVU;
          3'b110:  dec_op = OP_REM;
          default: dec_op = OP_REMU;
        endcase
      end else begin
        case (funct3)
          // I-type has no SUBI: instr[30] is immediate data there.
          3'b000:  dec_op = (alu_op == 2'b10 && funct7_5) ? OP_SUB : OP_ADD;
          3'b001:  dec_op = OP_SLL;
          3'b010:  dec_op = OP_SLT;
          3'b011:  dec_op = OP_SLTU;
          3'b100:  dec_op = OP_XOR;
          3'b101:  dec_op = funct7_5 ? OP_SRA : OP_SRL;
          3'b110:  dec_op = OP_OR;
          default: dec_op = OP_AND;
        endcase
      end
    end
  end

  // ---------------- base ALU ----------------
  logic [CW-1:0]   shamt;
  logic [XLEN-1:0] alu_res;
  assign shamt = src_b[CW-1:0];

  always_comb begin
    alu_res = '0;
    case (dec_op)
      OP_SUB:  alu_res = src_a - src_b;
      OP_SLL:  alu_res = src_a << shamt;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      OP_XOR:  alu_res = src_a ^ src_b;
      OP_SRL:  alu_res = src_a >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(src_a) >>> shamt);
      OP_OR:   alu_res = src_a | src_b;
      OP_AND:  alu_res = src_a & src_b;
      default: alu_res = src_a + src_b;
    endcase
  end

  // ---------------- M-op operand setup ----------------
  // The sequencer works on magnitudes; neg records whether the selected
  // output (product, quotient or remainder) must be negated at the end.
  logic            a_neg, b_neg, m_neg;
  logic [XLEN-1:0] a_abs, b_abs, a_mag, b_mag;
  assign a_neg = src_a[XLEN-1];
  assign b_neg = src_b[XLEN-1];
  assign a_abs = a_neg ? -src_a : src_a;
  assign b_abs = b_neg ? -src_b : src_b;

  always_comb begin
    a_mag = src_a;
    b_mag = src_b;
    m_neg = 1'b0;
    case (dec_op)
      OP_MULH, OP_DIV: begin a_mag = a_abs; b_mag = b_abs; m_neg = a_neg ^ b_neg; end
      OP_MULHSU:       begin a_mag = a_abs; m_neg = a_neg; end
      OP_REM:          begin a_mag = a_abs; b_mag = b_abs; m_neg = a_neg; end
      default: ;
    endcase
  end

  // ---------------- one iteration step ----------------
  // Multiply: {hi,lo} is a right-shifting product register, lo starts as the
  // multiplier. Divide: lo shifts the dividend out and the quotient in, hi
  // holds the partial remainder.
  logic            is_div;
  logic [XLEN:0]   mul_sum, rem_sh, trial;
  logic [XLEN-1:0] hi_step, lo_step;

  assign is_div = op_q inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};

  always_comb begin
    mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, bmag_q} : '0);
    rem_sh  = {hi_q, lo_q[XLEN-1]};
    trial   = rem_sh - {1'b0, bmag_q};
    if (!is_div) begin
      hi_step = mul_sum[XLEN:1];
      lo_step = {mul_sum[0], lo_q[XLEN-1:1]};
    end else if (!trial[XLEN]) begin
      hi_step = trial[XLEN-1:0];
      lo_step = {lo_q[XLEN-2:0], 1'b1};
    end else begin
      hi_step = rem_sh[XLEN-1:0];
      lo_step = {lo_q[XLEN-2:0], 1'b0};
    end
  end

  // ---------------- sign fix-up / result select ----------------
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   m_res;
  assign prod   = {hi_step, lo_step};
  assign prod_s = neg_q ? -prod : prod;

  always_comb begin
    m_res = '0;
    case (op_q)
      OP_MUL:                      m_res = lo_step;
      OP_MULH, OP_MULHSU, OP_MULHU: m_res = prod_s[2*XLEN-1:XLEN];
      // Divide-by-zero quotient is all ones regardless of dividend sign.
      OP_DIV, OP_DIVU:             m_res = dz_q ? '1 : (neg_q ? -lo_step : lo_step);
      OP_REM, OP_REMU:             m_res = neg_q ? -hi_step : hi_step;
      default: ;
    endcase
  end

  // ---------------- control ----------------
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    bmag_d   = bmag_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    result_d = result_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        op_d = dec_op;
        if (dec_op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
                           OP_DIV, OP_DIVU, OP_REM, OP_REMU}) begin
          state_d = S_ITER;
          cnt_d   = '0;
          hi_d    = '0;
          lo_d    = a_mag;
          bmag_d  = b_mag;
          neg_d   = m_neg;
          dz_d    = (src_b == '0);
        end else begin
          state_d  = S_DONE;
          result_d = alu_res;
          zero_d   = (alu_res == '0);
        end
      end
      S_ITER: begin
        hi_d  = hi_step;
        lo_d  = lo_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(XLEN - 1)) begin
          state_d  = S_DONE;
          result_d = m_res;
          zero_d   = (m_res == '0);
          cnt_d    = '0;
        end
      end
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples its _d value from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
    end
  end

  // NOTE: datapath registers are left out of reset; they are always loaded
  // at acceptance before being read.
  always_ff @(posedge clk) begin
    op_q   <= op_d;
    hi_q   <= hi_d;
    lo_q   <= lo_d;
    bmag_q <= bmag_d;
    neg_q  <= neg_d;
    dz_q   <= dz_d;
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign result    = result_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit
//   Directed bench for alu_exec_unit: a 32-bit M-enabled instance carries
//   most vectors; a 32-bit ENABLE_M=0 instance and a 16-bit instance cover
//   the parameter cases. Expected values are hand-computed constants.
module tb_alu_exec_unit;

  logic        clk, rst_n;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        funct7_5, funct7_0, out_ready;
  logic [31:0] src_a, src_b;

  logic        in_valid, in_ready, out_valid, zero;
  logic [31:0] result;

  logic        nm_valid, nm_in_ready, nm_out_valid, nm_zero;
  logic [31:0] nm_result;

  logic        v16_valid, v16_in_ready, v16_out_valid, v16_zero;
  logic [15:0] a16, b16, r16;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .src_a(src_a), .src_b(src_b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero));

  alu_exec_unit #(.XLEN(32), .ENABLE_M(1'b0)) dut_nm (
    .clk(clk), .rst_n(rst_n), .in_valid(nm_valid), .in_ready(nm_in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .src_a(src_a), .src_b(src_b), .out_valid(nm_out_valid), .out_ready(out_ready),
    .result(nm_result), .zero(nm_zero));

  alu_exec_unit #(.XLEN(16), .ENABLE_M(1'b1)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(v16_valid), .in_ready(v16_in_ready),
    .alu_op(alu_op), .funct3(funct3), .funct7_5(funct7_5), .funct7_0(funct7_0),
    .src_a(a16), .src_b(b16), .out_valid(v16_out_valid), .out_ready(out_ready),
    .result(r16), .zero(v16_zero));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Issue one op on the main instance, measure latency in edges from the
  // acceptance edge, check result/zero, then complete the output handshake.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [2:0] f3, input logic f75, input logic f70,
                        input logic [31:0] va, input logic [31:0] vb,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    @(negedge clk);
    alu_op = op; funct3 = f3; funct7_5 = f75; funct7_0 = f70;
    src_a = va; src_b = vb; out_ready = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " result"}, result, exp);
    check({tag, " zero"}, zero, exp == 32'h0);
    @(posedge clk); #1;
    check({tag, " back to idle"}, in_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int  lat;
    logic seen;
    clk = 0; rst_n = 0; in_valid = 1; nm_valid = 0; v16_valid = 0;
    out_ready = 1; alu_op = 2'b00; funct3 = 0; funct7_5 = 0; funct7_0 = 0;
    src_a = 32'd3; src_b = 32'd4; a16 = 0; b16 = 0;

    // Reset with in_valid high: nothing accepted.
    repeat (2) @(posedge clk);
    #1;
    check("reset out_valid", out_valid, 1'b0);
    check("reset result", result, 32'h0);
    check("reset zero", zero, 1'b0);
    @(negedge clk);
    rst_n = 1; in_valid = 0;
    #1 check("post-reset in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    check("post-reset out_valid", out_valid, 1'b0);

    // Base decode
    run_op("SUB r-type",   2'b10, 3'b000, 1, 0, 32'd5, 32'd7, 32'hFFFF_FFFE, 1);
    run_op("ADDI f7_5",    2'b11, 3'b000, 1, 0, 32'd5, 32'd7, 32'd12, 1);
    run_op("SRA",          2'b10, 3'b101, 1, 0, 32'h8000_0000, 32'd4, 32'hF800_0000, 1);
    run_op("SRLI",         2'b11, 3'b101, 0, 0, 32'h8000_0000, 32'd4, 32'h0800_0000, 1);
    run_op("SLL masked",   2'b10, 3'b001, 0, 0, 32'd1, 32'h21, 32'd2, 1);
    run_op("SLT",          2'b10, 3'b010, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run_op("SLTU",         2'b10, 3'b011, 0, 0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1);
    run_op("XOR",          2'b10, 3'b100, 0, 0, 32'hF0F0_1234, 32'h0FF0_1234, 32'hFF00_0000, 1);
    run_op("ORI",          2'b11, 3'b110, 0, 0, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1);
    run_op("AND",          2'b10, 3'b111, 0, 0, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1);
    run_op("ld/st add",    2'b00, 3'b111, 1, 1, 32'hFFFF_FFFF, 32'd2, 32'd1, 1);

    // Branch compare with output stall
    @(negedge clk);
    alu_op = 2'b01; funct3 = 0; funct7_5 = 0; funct7_0 = 0;
    src_a = 32'h1234; src_b = 32'h1234; out_ready = 0; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    check("branch out_valid", out_valid, 1'b1);
    check("branch result", result, 32'h0);
    check("branch zero", zero, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stall out_valid", out_valid, 1'b1);
      check("stall result", result, 32'h0);
      check("stall in_ready", in_ready, 1'b0);
    end
    @(negedge clk);
    out_ready = 1;
    @(posedge clk); #1;
    check("stall release in_ready", in_ready, 1'b1);
    check("stall release out_valid", out_valid, 1'b0);

    // Multiply
    run_op("MULH -1*-1",  2'b10, 3'b001, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33);
    run_op("MULHU",       2'b10, 3'b011, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run_op("MUL 2^32",    2'b10, 3'b000, 0, 1, 32'h0001_0000, 32'h0001_0000, 32'h0, 33);
    run_op("MUL 6*7",     2'b10, 3'b000, 0, 1, 32'd6, 32'd7, 32'd42, 33);
    run_op("MULHSU -1*2", 2'b10, 3'b010, 0, 1, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);

    // Divide
    run_op("DIV 7/0",      2'b10, 3'b100, 0, 1, 32'd7, 32'd0, 32'hFFFF_FFFF, 33);
    run_op("REMU 7/0",     2'b10, 3'b111, 0, 1, 32'd7, 32'd0, 32'd7, 33);
    run_op("DIV overflow", 2'b10, 3'b100, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33);
    run_op("REM overflow", 2'b10, 3'b110, 0, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 33);
    run_op("DIV -7/2",     2'b10, 3'b100, 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("REM -7/2",     2'b10, 3'b110, 0, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("DIVU 100/7",   2'b10, 3'b101, 0, 1, 32'd100, 32'd7, 32'd14, 33);
    run_op("REMU 100/7",   2'b10, 3'b111, 0, 1, 32'd100, 32'd7, 32'd2, 33);

    // Reset in the middle of a DIVU aborts it
    @(negedge clk);
    alu_op = 2'b10; funct3 = 3'b101; funct7_5 = 0; funct7_0 = 1;
    src_a = 32'd100; src_b = 32'd7; out_ready = 1; in_valid = 1;
    @(posedge clk); #1;
    in_valid = 0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 0;
    @(posedge clk); #1;
    check("abort out_valid", out_valid, 1'b0);
    check("abort in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("abort no result", seen, 1'b0);

    // ENABLE_M=0: funct7_0 ignored, plain ADD in one cycle
    @(negedge clk);
    alu_op = 2'b10; funct3 = 3'b000; funct7_5 = 0; funct7_0 = 1;
    src_a = 32'd5; src_b = 32'd7; nm_valid = 1;
    @(posedge clk); #1;
    nm_valid = 0;
    check("noM out_valid", nm_out_valid, 1'b1);
    check("noM result", nm_result, 32'd12);
    @(posedge clk); #1;
    check("noM idle", nm_in_ready, 1'b1);

    // XLEN=16 DIVU
    @(negedge clk);
    alu_op = 2'b10; funct3 = 3'b101; funct7_5 = 0; funct7_0 = 1;
    a16 = 16'hFFFF; b16 = 16'd3; v16_valid = 1;
    @(posedge clk); #1;
    v16_valid = 0;
    lat = 1;
    while (!v16_out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check("x16 DIVU latency", lat, 17);
    check("x16 DIVU result", r16, 16'h5555);
    @(posedge clk); #1;
    check("x16 idle", v16_in_ready, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
